// File: rtl/fma16_pkg.sv
// Shared definitions for the binary16 divider: field widths, constants,
// flag bit positions and the sequencing state type.
package fma16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int MANT_W = FRAC_W + 1;
  localparam int QUO_W  = MANT_W + 2;
  localparam int BIAS   = 15;

  localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;
  localparam logic [15:0]      QNAN    = 16'h7E00;

  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIVZERO   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fma16_fdiv_special.sv
// Operand classification for the divider; decides whether the quotient is
// fully determined by operand class and, if so, its value and flags.
module fma16_fdiv_special
  import fma16_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic        special,
  output logic [15:0] result,
  output logic [4:0]  flags
);

  logic sign;
  logic zero_x, inf_x, nan_x, snan_x;
  logic zero_y, inf_y, nan_y, snan_y;

  // Subnormals land in the zero class: exponent field alone decides.
  assign zero_x = (x[14:10] == '0);
  assign inf_x  = (x[14:10] == EXP_MAX) && (x[9:0] == '0);
  assign nan_x  = (x[14:10] == EXP_MAX) && (x[9:0] != '0);
  assign snan_x = nan_x && !x[9];
  assign zero_y = (y[14:10] == '0);
  assign inf_y  = (y[14:10] == EXP_MAX) && (y[9:0] == '0);
  assign nan_y  = (y[14:10] == EXP_MAX) && (y[9:0] != '0);
  assign snan_y = nan_y && !y[9];
  assign sign   = x[15] ^ y[15];

  always_comb begin
    special = 1'b1;
    result  = '0;
    flags   = '0;
    if (nan_x || nan_y) begin
      result              = QNAN;
      flags[FLAG_INVALID] = snan_x || snan_y;
    end else if ((zero_x && zero_y) || (inf_x && inf_y)) begin
      result              = QNAN;
      flags[FLAG_INVALID] = 1'b1;
    end else if (inf_x) begin
      result = {sign, EXP_MAX, 10'd0};
    end else if (zero_y) begin
      result              = {sign, EXP_MAX, 10'd0};
      flags[FLAG_DIVZERO] = 1'b1;
    end else if (inf_y || zero_x) begin
      result = {sign, 15'd0};
    end else begin
      special = 1'b0;
    end
  end

endmodule

// File: rtl/fma16_fdiv.sv
// Sequential binary16 divider: restoring quotient, one bit per cycle,
// round-to-nearest-even with flush-to-zero on both inputs and outputs.
//
// state | meaning
// IDLE  | waiting for start; specials resolve straight to DONE
// DIV   | one restoring quotient bit per cycle, count runs 13 -> 1
// ROUND | RNE rounding, exponent range check, result/flags latched
// DONE  | done pulse, result/flags valid
module fma16_fdiv
  import fma16_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [4:0]  flags
);

  state_t state, state_next;

  logic [MANT_W:0]       rem;
  logic [MANT_W-1:0]     dvs;
  logic [QUO_W-1:0]      quo;
  logic signed [6:0]     exp_q;
  logic                  sign_q;
  logic [3:0]            count;
  logic [15:0]           result_q;
  logic [4:0]            flags_q;

  logic                  sp_special;
  logic [15:0]           sp_result;
  logic [4:0]            sp_flags;

  fma16_fdiv_special u_special (
    .x       (x),
    .y       (y),
    .special (sp_special),
    .result  (sp_result),
    .flags   (sp_flags)
  );

  logic [MANT_W-1:0] mx, my;
  logic              mx_lt;
  logic signed [6:0] exp_init;

  assign mx       = {1'b1, x[9:0]};
  assign my       = {1'b1, y[9:0]};
  assign mx_lt    = (mx < my);
  assign exp_init = $signed({2'b00, x[14:10]}) - $signed({2'b00, y[14:10]})
                  + 7'sd15 - $signed({6'd0, mx_lt});

  // Remainder stays below 2*divisor, so the shifted difference fits 12 bits.
  logic              ge;
  logic [MANT_W:0]   diff;
  logic [MANT_W:0]   rem_next;

  assign ge       = (rem >= {1'b0, dvs});
  assign diff     = rem - {1'b0, dvs};
  assign rem_next = ge ? {diff[MANT_W-1:0], 1'b0} : {rem[MANT_W-1:0], 1'b0};

  logic              guard, rnd, sticky, round_up, carry, inexact;
  logic [MANT_W:0]   sum;
  logic signed [6:0] exp_r;
  logic [15:0]       round_result;
  logic [4:0]        round_flags;

  assign guard    = quo[1];
  assign rnd      = quo[0];
  assign sticky   = |rem;
  assign round_up = guard && (rnd || sticky || quo[2]);
  assign sum      = {1'b0, quo[QUO_W-1:2]} + {{MANT_W{1'b0}}, round_up};
  assign carry    = sum[MANT_W];
  assign exp_r    = exp_q + $signed({6'd0, carry});
  assign inexact  = guard || rnd || sticky;

  always_comb begin
    round_result = '0;
    round_flags  = '0;
    if (exp_r >= 7'sd31) begin
      round_result                = {sign_q, EXP_MAX, 10'd0};
      round_flags[FLAG_OVERFLOW]  = 1'b1;
      round_flags[FLAG_INEXACT]   = 1'b1;
    end else if (exp_r <= 7'sd0) begin
      round_result                = {sign_q, 15'd0};
      round_flags[FLAG_UNDERFLOW] = 1'b1;
      round_flags[FLAG_INEXACT]   = 1'b1;
    end else begin
      // A carry to 2.0 leaves an all-zero fraction after the shift.
      round_result              = {sign_q, exp_r[4:0], carry ? 10'd0 : sum[9:0]};
      round_flags[FLAG_INEXACT] = inexact;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = sp_special ? DONE : DIV;
      DIV:     if (count == 4'd1) state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem      <= '0;
      dvs      <= '0;
      quo      <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      count    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (sp_special) begin
              result_q <= sp_result;
              flags_q  <= sp_flags;
            end else begin
              rem    <= mx_lt ? {mx, 1'b0} : {1'b0, mx};
              dvs    <= my;
              quo    <= '0;
              exp_q  <= exp_init;
              sign_q <= x[15] ^ y[15];
              count  <= 4'd13;
            end
          end
        end
        DIV: begin
          quo   <= {quo[QUO_W-2:0], ge};
          rem   <= rem_next;
          count <= count - 4'd1;
        end
        ROUND: begin
          result_q <= round_result;
          flags_q  <= round_flags;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: doc/fma16_fdiv.md
FMA16_FDIV -- requirements
Module: fma16_fdiv

Interface
REQ-001 SHALL have parameter none; format fixed IEEE binary16 (1 sign, 5 exp, 10 frac, bias 15).
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 x  input  16  dividend, captured on the accepting edge.
REQ-006 y  input  16  divisor, captured on the accepting edge.
REQ-007 busy  output  1  high from the accepting edge until done falls.
REQ-008 done  output  1  one-cycle pulse, result/flags valid.
REQ-009 result  output  16  quotient; held from done until the next accepted start.
REQ-010 flags  output  5  {invalid, divzero, overflow, underflow, inexact}; held like result.

Function
REQ-011 SHALL use FSM states IDLE, DIV, ROUND, DONE.
REQ-012 IDLE: start=1 -> capture x, y; special operand -> DONE; else -> DIV with count 13.
REQ-013 DIV: one restoring quotient bit per cycle; after 13 bits -> ROUND; ROUND -> DONE; DONE -> IDLE.
REQ-014 done SHALL be high exactly in the DONE cycle.
REQ-015 Latency: 15 cycles (normal operands) and 1 cycle (special operands) from the accepting edge to the edge that enters DONE.
REQ-016 start during busy SHALL be ignored; start in the DONE cycle is ignored; back-to-back requests are accepted only in IDLE.
REQ-017 Subnormal inputs SHALL be treated as signed zero (flush-to-zero); no flag is raised for the flush.
REQ-018 Sign = sign_x XOR sign_y for all non-NaN results.
REQ-019 Pre-normalise: mx, my = {1, frac} (11 bits); if mx < my, the dividend is mx<<1 and the exponent is decremented, so the quotient lies in [1,2).
REQ-020 Biased exponent e = ex - ey + 15 (- 1 per REQ-019), computed at 7-bit signed width.
REQ-021 Quotient SHALL be 13 bits (1 integer, 10 fraction, guard, round); sticky = (final remainder != 0).
REQ-022 ROUND: round-to-nearest-even on guard/round/sticky; if a carry out to 2.0 occurs, shift right and increment e.
REQ-023 e >= 31 after rounding -> result signed inf 0x7C00/0xFC00, overflow=1, inexact=1.
REQ-024 e <= 0 -> result signed zero, underflow=1, inexact=1 (no subnormal outputs).
REQ-025 inexact SHALL be 1 when any of guard, round, sticky is nonzero.
REQ-026 NaN operand -> 0x7E00; invalid=1 only if either operand is sNaN (exp=31, frac!=0, frac[9]=0).
REQ-027 0/0 or inf/inf -> 0x7E00, invalid=1.
REQ-028 finite nonzero/0 -> signed inf, divzero=1; inf/finite -> signed inf, no flags; finite/inf and 0/finite nonzero -> signed zero, no flags.

Reset
REQ-029 reset SHALL force state IDLE, busy=0, done=0, result=0x0000, flags=0, count=0 and cancel any operation in progress; the aborted operation produces no done.
REQ-030 When reset and start are high in the same cycle, reset SHALL win.

Structure
REQ-031 Shared package fma16_pkg SHALL hold the state enum, the FP16 field widths, BIAS=15, QNAN=16'h7E00, and the flag bit indices.
REQ-032 Operand classification (zero/inf/NaN/sNaN, special result and flags) SHALL live in the combinational sub-module fma16_fdiv_special.
REQ-033 Datapath registers: mantissa dividend/remainder (12 bits), divisor (11), quotient shift (13), exponent (7), sign, count (4).

Verification
REQ-034 x=0x3C00, y=0x3C00, start -> done at cycle 15, result 0x3C00, flags 0.
REQ-035 x=0x3C00, y=0x4200 (1/3) -> result 0x3555, flags 00001; x=0x4600, y=0x4000 -> 0x4200, flags 0.
REQ-036 x=0x3C00, y=0x0000 -> done at cycle 1, result 0x7C00, flags 01000; x=0x0000, y=0x0000 -> 0x7E00, flags 10000.
REQ-037 x=0x7BFF, y=0x1400 -> 0x7C00, flags 00101; x=0x0400, y=0x7BFF -> 0x0000, flags 00011.
REQ-038 x=0x7D00 (sNaN), y=0x3C00 -> 0x7E00, flags 10000; start pulsed during busy -> ignored, only one done.
REQ-039 reset asserted at cycle 5 of a division -> next cycle IDLE, busy=0, result=0x0000, no done; a new start then completes normally.
